// File: rtl/qix_nvram_xfer.sv
// NVRAM transfer engine: streams NVRAM to the host (SAVE), from the host (LOAD), or fills it (CLEAR).
// Define NVRAM_CHECKSUM_EN to enable the running mod-256 checksum on chk; otherwise chk is tied to 0.
module qix_nvram_xfer #(
    parameter int         NV_SIZE = 1024,
    parameter logic [7:0] FILL    = 8'h00
) (
    input  logic        clk_20m,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cmd,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [15:0] hs_address,
    output logic [7:0]  hs_data_in,
    output logic        hs_write,
    input  logic [7:0]  hs_data_out,
    output logic        pause_req,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [7:0]  chk
);

    // state     | meaning
    // IDLE      | waiting for an accepted start
    // SAVE_RD   | counter presented as NVRAM address
    // SAVE_WAIT | read data returning, captured into out_data
    // SAVE_OUT  | byte offered to host until out_ready
    // LOAD      | accepting host bytes, each written one cycle later
    // CLEAR     | writing FILL to every address
    // DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE_RD,
        S_SAVE_WAIT,
        S_SAVE_OUT,
        S_LOAD,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [9:0] LAST = 10'(NV_SIZE - 1);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] acc_addr;
    logic [7:0] hs_data_in_q, hs_data_in_d;
    logic       hs_write_q, hs_write_d;
    logic [7:0] out_data_q, out_data_d;
    logic       load_last_q, load_last_d;
    logic       aborted_q, aborted_d;
    logic       go;

    assign go = (state_q == S_IDLE) && start && !abort && (cmd != 2'd3);

    always_ff @(posedge clk_20m or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hs_data_in_q <= '0;
            hs_write_q   <= 1'b0;
            out_data_q   <= '0;
            load_last_q  <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hs_data_in_q <= hs_data_in_d;
            hs_write_q   <= hs_write_d;
            out_data_q   <= out_data_d;
            load_last_q  <= load_last_d;
            aborted_q    <= aborted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hs_data_in_d = hs_data_in_q;
        hs_write_d   = 1'b0;
        out_data_d   = out_data_q;
        load_last_d  = load_last_q;
        aborted_d    = 1'b0;
        // In LOAD the counter still holds the address being written, so a byte
        // accepted alongside a pending write lands one address further on.
        acc_addr     = hs_write_q ? cnt_q + 10'd1 : cnt_q;

        if ((state_q != S_IDLE) && abort) begin
            state_d     = S_IDLE;
            aborted_d   = 1'b1;
            load_last_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        cnt_d       = '0;
                        load_last_d = 1'b0;
                        case (cmd)
                            2'd0:    state_d = S_SAVE_RD;
                            2'd1:    state_d = S_LOAD;
                            default: begin
                                state_d      = S_CLEAR;
                                hs_write_d   = 1'b1;
                                hs_data_in_d = FILL;
                            end
                        endcase
                    end
                end
                S_SAVE_RD:   state_d = S_SAVE_WAIT;
                S_SAVE_WAIT: begin
                    out_data_d = hs_data_out;
                    state_d    = S_SAVE_OUT;
                end
                S_SAVE_OUT: begin
                    if (out_ready) begin
                        if (cnt_q == LAST) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = cnt_q + 10'd1;
                            state_d = S_SAVE_RD;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_last_q) begin
                        state_d     = S_DONE;
                        load_last_d = 1'b0;
                    end else begin
                        if (hs_write_q) begin
                            cnt_d = cnt_q + 10'd1;
                        end
                        if (in_valid) begin
                            hs_write_d   = 1'b1;
                            hs_data_in_d = in_data;
                            if (acc_addr == LAST) begin
                                load_last_d = 1'b1;
                            end
                        end
                    end
                end
                S_CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d      = cnt_q + 10'd1;
                        hs_write_d = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        pause_req  = (state_q != S_IDLE);
        out_valid  = (state_q == S_SAVE_OUT);
        in_ready   = (state_q == S_LOAD) && !load_last_q;
        done       = (state_q == S_DONE) && !abort;
        aborted    = aborted_q;
        hs_write   = hs_write_q;
        hs_data_in = hs_data_in_q;
        out_data   = out_data_q;
        hs_address = {6'b000000, cnt_q};
    end

`ifdef NVRAM_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    // Every issued write counts, including one still in flight when abort arrives.
    always_comb begin
        chk_d = chk_q;
        if (go) begin
            chk_d = '0;
        end else if (hs_write_q) begin
            chk_d = chk_q + hs_data_in_q;
        end else if ((state_q == S_SAVE_OUT) && out_ready && !abort) begin
            chk_d = chk_q + out_data_q;
        end
    end

    always_ff @(posedge clk_20m or posedge reset) begin
        if (reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk = chk_q;
`else
    assign chk = 8'h00;
`endif

endmodule

// File: tb/tb_qix_nvram_xfer.sv
// Scoreboard bench for qix_nvram_xfer: CLEAR, LOAD, SAVE, abort, ignored starts and async reset.
`timescale 1ns/1ps
module tb_qix_nvram_xfer;
    localparam int         NV     = 1024;
    localparam logic [7:0] FILL_V = 8'hA5;
`ifdef NVRAM_CHECKSUM_EN
    localparam logic [31:0] CHK_MASK = 32'h0000_00FF;
`else
    localparam logic [31:0] CHK_MASK = 32'h0000_0000;
`endif

    logic        clk_20m = 1'b0;
    logic        reset, start, abort, in_valid, out_ready;
    logic [1:0]  cmd;
    logic [7:0]  in_data, out_data, hs_data_in, hs_data_out, chk;
    logic        in_ready, out_valid, hs_write, pause_req, busy, done, aborted;
    logic [15:0] hs_address;

    logic [7:0]  nvram   [NV];
    logic [7:0]  ref_mem [NV];
    int          wq_addr[$];
    logic [7:0]  wq_data[$];
    logic [7:0]  rq[$];
    int          n_cmp = 0, n_mis = 0, n_wr = 0, n_out = 0;
    int          k, idx, done_k, wr0, out0, ea;
    logic [7:0]  sum, ed;
    logic        seen, prev_hold;
    logic [7:0]  prev_data;

    qix_nvram_xfer #(.NV_SIZE(NV), .FILL(FILL_V)) dut (
        .clk_20m(clk_20m), .reset(reset), .start(start), .cmd(cmd), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
        .hs_data_out(hs_data_out), .pause_req(pause_req), .busy(busy), .done(done),
        .aborted(aborted), .chk(chk)
    );

    always #25 clk_20m = ~clk_20m;

    // NVRAM model: synchronous write, read data one cycle after the address
    always @(posedge clk_20m) begin
        if (hs_write) nvram[hs_address[9:0]] <= hs_data_in;
        hs_data_out <= nvram[hs_address[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_chk(input logic [7:0] s);
        return 32'(s) & CHK_MASK;
    endfunction

    task automatic issue_start(input logic [1:0] c);
        @(posedge clk_20m); #1;
        start = 1'b1;
        cmd   = c;
        @(posedge clk_20m); #1;
        start = 1'b0;
    endtask

    // Scoreboard consumer: NVRAM writes and SAVE handshakes
    always @(negedge clk_20m) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (hs_write) begin
                n_wr++;
                n_cmp++;
                assert (wq_addr.size() != 0) else begin
                    n_mis++;
                    $error("FAIL write_extra: observed write %0h@%0h, expected none", hs_data_in, hs_address);
                end
                if (wq_addr.size() != 0) begin
                    ea = wq_addr.pop_front();
                    ed = wq_data.pop_front();
                    check("write_addr", 32'(hs_address), 32'(ea));
                    check("write_data", 32'(hs_data_in), 32'(ed));
                end
            end
            if (prev_hold && out_valid) check("save_hold", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) begin
                n_out++;
                n_cmp++;
                assert (rq.size() != 0) else begin
                    n_mis++;
                    $error("FAIL save_extra: observed byte %0h, expected none", out_data);
                end
                if (rq.size() != 0) begin
                    ed = rq.pop_front();
                    check("save_data", 32'(out_data), 32'(ed));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; cmd = 2'd0; abort = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (3) @(posedge clk_20m);
        @(negedge clk_20m);
        check("rst_busy", 32'(busy), 0);
        check("rst_pause", 32'(pause_req), 0);
        check("rst_hs_write", 32'(hs_write), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_aborted", 32'(aborted), 0);
        check("rst_hs_address", 32'(hs_address), 0);
        check("rst_hs_data_in", 32'(hs_data_in), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_chk", 32'(chk), 0);
        @(posedge clk_20m); #1;
        reset = 1'b0;

        // reserved command is ignored
        issue_start(2'd3);
        @(negedge clk_20m);
        check("cmd3_busy", 32'(busy), 0);
        check("cmd3_pause", 32'(pause_req), 0);
        check("cmd3_aborted", 32'(aborted), 0);

        // start together with abort in IDLE
        @(posedge clk_20m); #1;
        start = 1'b1; cmd = 2'd2; abort = 1'b1;
        @(posedge clk_20m); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk_20m);
        check("sa_busy", 32'(busy), 0);
        check("sa_aborted", 32'(aborted), 0);
        check("sa_done", 32'(done), 0);
        check("sa_hs_write", 32'(hs_write), 0);

        // CLEAR, with a stray start mid-command
        wr0 = n_wr;
        for (int i = 0; i < NV; i++) begin
            ref_mem[i] = FILL_V;
            wq_addr.push_back(i);
            wq_data.push_back(FILL_V);
        end
        issue_start(2'd2);
        k = 0; done_k = 0;
        while (done_k == 0 && k < 1200) begin
            k++;
            if (k == 100) begin start = 1'b1; cmd = 2'd1; end
            @(negedge clk_20m);
            if (k == 1) check("clear_pause", 32'(pause_req), 1);
            if (done) begin
                done_k = k;
                check("clear_pause_done", 32'(pause_req), 1);
            end
            @(posedge clk_20m); #1;
            start = 1'b0;
        end
        check("clear_done_cycle", 32'(done_k), 1025);
        check("clear_writes", 32'(n_wr - wr0), NV);
        check("clear_queue", 32'(wq_addr.size()), 0);
        check("clear_chk", 32'(chk), exp_chk(8'h00));
        @(negedge clk_20m);
        check("clear_idle_busy", 32'(busy), 0);
        check("clear_idle_pause", 32'(pause_req), 0);
        check("clear_done_once", 32'(done), 0);

        // LOAD, value = addr[7:0], in_valid held high
        @(posedge clk_20m); #1;
        wr0 = n_wr; sum = 8'h00;
        for (int i = 0; i < NV; i++) begin
            ref_mem[i] = 8'(i);
            wq_addr.push_back(i);
            wq_data.push_back(ref_mem[i]);
            sum = sum + ref_mem[i];
        end
        issue_start(2'd1);
        idx = 0; k = 0; done_k = 0;
        while (done_k == 0 && k < 1300) begin
            k++;
            in_valid = 1'b1;
            in_data  = (idx < NV) ? ref_mem[idx] : 8'hEE;
            @(negedge clk_20m);
            if (idx == NV) check("load_ready_low", 32'(in_ready), 0);
            else if (in_ready) idx++;
            if (done) done_k = k;
            @(posedge clk_20m); #1;
        end
        in_valid = 1'b0;
        check("load_accepted", 32'(idx), NV);
        check("load_done_cycle", 32'(done_k), 1026);
        check("load_writes", 32'(n_wr - wr0), NV);
        check("load_queue", 32'(wq_addr.size()), 0);
        check("load_chk", 32'(chk), exp_chk(sum));
        @(negedge clk_20m);
        check("load_done_once", 32'(done), 0);
        check("load_idle_busy", 32'(busy), 0);

        // SAVE with random out_ready back-pressure
        @(posedge clk_20m); #1;
        wr0 = n_wr; out0 = n_out; sum = 8'h00;
        for (int i = 0; i < NV; i++) begin
            rq.push_back(ref_mem[i]);
            sum = sum + ref_mem[i];
        end
        issue_start(2'd0);
        k = 0; done_k = 0;
        while (done_k == 0 && k < 8000) begin
            k++;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk_20m);
            if (k == 1) check("save_addr0", 32'(hs_address), 0);
            if (done) done_k = k;
            @(posedge clk_20m); #1;
        end
        out_ready = 1'b0;
        check("save_done_seen", 32'(done_k != 0), 1);
        check("save_bytes", 32'(n_out - out0), NV);
        check("save_queue", 32'(rq.size()), 0);
        check("save_no_writes", 32'(n_wr - wr0), 0);
        check("save_chk", 32'(chk), exp_chk(sum));

        // abort during LOAD after 10 bytes; byte offered in the abort cycle must be dropped
        wr0 = n_wr; sum = 8'h00;
        for (int i = 0; i < 10; i++) begin
            ref_mem[i] = 8'($urandom);
            wq_addr.push_back(i);
            wq_data.push_back(ref_mem[i]);
            sum = sum + ref_mem[i];
        end
        issue_start(2'd1);
        idx = 0; k = 0;
        while (idx < 10 && k < 50) begin
            k++;
            in_valid = 1'b1;
            in_data  = ref_mem[idx];
            @(negedge clk_20m);
            if (in_ready) idx++;
            @(posedge clk_20m); #1;
        end
        check("abort_accepts", 32'(idx), 10);
        in_data = 8'h5A; abort = 1'b1;
        @(posedge clk_20m); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk_20m);
        check("abort_pulse", 32'(aborted), 1);
        check("abort_no_done", 32'(done), 0);
        check("abort_pause", 32'(pause_req), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_no_write", 32'(hs_write), 0);
        @(posedge clk_20m); #1;
        @(negedge clk_20m);
        check("abort_once", 32'(aborted), 0);
        check("abort_writes", 32'(n_wr - wr0), 10);
        check("abort_queue", 32'(wq_addr.size()), 0);
        check("abort_chk", 32'(chk), exp_chk(sum));

        // async reset while in SAVE_OUT
        out_ready = 1'b0;
        issue_start(2'd0);
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            k++;
            @(negedge clk_20m);
            seen = out_valid;
            if (!seen) begin @(posedge clk_20m); #1; end
        end
        check("rst_saw_out_valid", 32'(seen), 1);
        #5 reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_pause", 32'(pause_req), 0);
        @(posedge clk_20m); #1;
        reset = 1'b0;

        // restarted SAVE must begin at address 0
        out0 = n_out;
        rq.push_back(ref_mem[0]);
        issue_start(2'd0);
        @(negedge clk_20m);
        check("restart_addr", 32'(hs_address), 0);
        k = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            k++;
            @(posedge clk_20m); #1;
            out_ready = 1'b1;
            @(negedge clk_20m);
            seen = out_valid;
        end
        @(posedge clk_20m); #1;
        out_ready = 1'b0; abort = 1'b1;
        @(posedge clk_20m); #1;
        abort = 1'b0;
        @(negedge clk_20m);
        check("restart_bytes", 32'(n_out - out0), 1);
        check("restart_queue", 32'(rq.size()), 0);
        check("restart_aborted", 32'(aborted), 1);
        check("restart_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
